// File: rtl/reg_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_bank_pkg
// Purpose  : Shared definitions for the reg_bank register bank: access-FSM
//            state encoding, per-register access modes and the helper that
//            maps the RO/W1C masks onto a mode for one register index.
// Options  : REG_BANK_SHADOW_EN (see reg_bank / reg_bank_cell)
// Revision : 1.0 - initial release
// ============================================================================
package reg_bank_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    localparam logic [1:0] MODE_RW  = 2'd0;
    localparam logic [1:0] MODE_RO  = 2'd1;
    localparam logic [1:0] MODE_W1C = 2'd2;

    // W1C takes precedence: an RO+W1C register is still a status register
    // (hw_set accumulates); the top keeps the bus from clearing it.
    function automatic logic [1:0] mode_of(input int i,
                                           input logic [63:0] ro_mask,
                                           input logic [63:0] w1c_mask);
        logic [1:0] m;
        if (w1c_mask[i])     m = MODE_W1C;
        else if (ro_mask[i]) m = MODE_RO;
        else                 m = MODE_RW;
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_bank_cell.sv
`default_nettype none
// ============================================================================
// Module   : reg_bank_cell
// Purpose  : One DW-bit register of the bank. Behaviour chosen by MODE:
//            RW  - bus write loads wdata (optionally via a shadow copy),
//            RO  - constant reset value,
//            W1C - bus write-1-to-clear, hw_set sets (set wins).
// Ports    : clk, rst_n (async, active-low), i_wr (bus write strobe),
//            i_wdata, i_hw_set, [i_commit], o_q (active value -> dout),
//            o_rd (bus-visible value -> read mux)
// Options  : REG_BANK_SHADOW_EN adds i_commit and a shadow flop for RW mode
// Revision : 1.0 - initial release
// ============================================================================
module reg_bank_cell
    import reg_bank_pkg::*;
#(
    parameter int          DW   = 8,
    parameter logic [1:0]  MODE = MODE_RW,
    parameter logic [DW-1:0] INI = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_wr,
    input  logic [DW-1:0] i_wdata,
    input  logic [DW-1:0] i_hw_set,
`ifdef REG_BANK_SHADOW_EN
    input  logic          i_commit,
`endif
    output logic [DW-1:0] o_q,
    output logic [DW-1:0] o_rd
);

    generate
        if (MODE == MODE_W1C) begin : g_w1c
            logic [DW-1:0] r_q;
`ifdef REG_BANK_SHADOW_EN
            logic w_unused;
            assign w_unused = i_commit;
`endif
            // hw_set is OR-ed in after the clear so a coincident set wins.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)    r_q <= INI;
                else if (i_wr) r_q <= (r_q & ~i_wdata) | i_hw_set;
                else           r_q <= r_q | i_hw_set;
            end
            assign o_q  = r_q;
            assign o_rd = r_q;
        end else if (MODE == MODE_RO) begin : g_ro
            logic w_unused;
`ifdef REG_BANK_SHADOW_EN
            assign w_unused = ^{clk, rst_n, i_wr, i_wdata, i_hw_set, i_commit};
`else
            assign w_unused = ^{clk, rst_n, i_wr, i_wdata, i_hw_set};
`endif
            assign o_q  = INI;
            assign o_rd = INI;
        end else begin : g_rw
            logic w_unused;
            assign w_unused = ^i_hw_set;
`ifdef REG_BANK_SHADOW_EN
            logic [DW-1:0] r_sh;
            logic [DW-1:0] r_act;
            // Bus sees the shadow; commit copies it to the active flop,
            // taking the same-cycle write value if there is one.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sh  <= INI;
                    r_act <= INI;
                end else begin
                    if (i_wr)     r_sh  <= i_wdata;
                    if (i_commit) r_act <= i_wr ? i_wdata : r_sh;
                end
            end
            assign o_q  = r_act;
            assign o_rd = r_sh;
`else
            logic [DW-1:0] r_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)    r_q <= INI;
                else if (i_wr) r_q <= i_wdata;
            end
            assign o_q  = r_q;
            assign o_rd = r_q;
`endif
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/reg_bank.sv
`default_nettype none
// ============================================================================
// Module   : reg_bank
// Purpose  : NREG x DW configuration/status register bank behind a req/ack
//            access port. Holds the access FSM, address decode, read mux and
//            the registered status interrupt.
// Ports    : clk, rst_n (async, active-low), req/we/addr/wdata (request),
//            ack/rdata/err (one-cycle response), hw_set (status set strobes),
//            dout (flattened register contents), irq (OR of W1C bits),
//            commit (only with REG_BANK_SHADOW_EN)
// Options  : REG_BANK_SHADOW_EN - shadowed RW registers plus commit input
// Revision : 1.0 - initial release
// ============================================================================
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int                 DW       = 8,
    parameter int                 NREG     = 8,
    parameter int                 AW       = 3,
    parameter logic [NREG*DW-1:0] INI      = '0,
    parameter logic [NREG-1:0]    RO_MASK  = '0,
    parameter logic [NREG-1:0]    W1C_MASK = '0,
    parameter int                 DLY      = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req,
    input  logic               we,
    input  logic [AW-1:0]      addr,
    input  logic [DW-1:0]      wdata,
    output logic               ack,
    output logic [DW-1:0]      rdata,
    output logic               err,
    input  logic [NREG*DW-1:0] hw_set,
`ifdef REG_BANK_SHADOW_EN
    input  logic               commit,
`endif
    output logic [NREG*DW-1:0] dout,
    output logic               irq
);

    state_t          r_state;
    state_t          w_next;
    logic            w_accept;
    logic            w_in_range;
    logic            w_blocked;
    logic [DW-1:0]   w_rd_mux;
    logic [DW-1:0]   r_rdata;
    logic            r_err;
    logic            r_irq;
    logic            w_w1c_or;
    logic            w_ini_or;
    logic [NREG-1:0] w_wr;
    logic [DW-1:0]   w_q  [NREG];
    logic [DW-1:0]   w_rd [NREG];

    // DLY is kept so existing instantiations still elaborate; assignments
    // carry no delay.
    logic w_unused_dly;
    assign w_unused_dly = (DLY != 0);

    // ---------------- access FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            IDLE: begin
                if (req) begin
                    w_accept = 1'b1;
                    w_next   = RESP;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // ---------------- decode / read mux ----------------
    assign w_in_range = (32'(addr) < NREG);

    always_comb begin
        w_rd_mux  = '0;
        w_blocked = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            if (32'(addr) == i) begin
                w_rd_mux  = w_rd[i];
                w_blocked = RO_MASK[i] & ~W1C_MASK[i];
            end
        end
    end

    // Response flops: loaded at the accept edge, zero otherwise, so they
    // are only non-zero in the RESP cycle alongside ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_rdata <= (w_accept && !we && w_in_range) ? w_rd_mux : '0;
            r_err   <= w_accept && (!w_in_range || (we && w_blocked));
        end
    end

    assign ack   = (r_state == RESP);
    assign rdata = r_rdata;
    assign err   = r_err;

    // ---------------- register cells ----------------
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_cell
            localparam logic [1:0] C_MODE = mode_of(gi, 64'(RO_MASK), 64'(W1C_MASK));

            // RO registers (including RO status registers) never take bus writes.
            assign w_wr[gi] = w_accept & we & (32'(addr) == gi) & ~RO_MASK[gi];

            reg_bank_cell #(
                .DW   (DW),
                .MODE (C_MODE),
                .INI  (INI[gi*DW +: DW])
            ) u_cell (
                .clk      (clk),
                .rst_n    (rst_n),
                .i_wr     (w_wr[gi]),
                .i_wdata  (wdata),
                .i_hw_set (hw_set[gi*DW +: DW]),
`ifdef REG_BANK_SHADOW_EN
                .i_commit (commit),
`endif
                .o_q      (w_q[gi]),
                .o_rd     (w_rd[gi])
            );

            assign dout[gi*DW +: DW] = w_q[gi];
        end
    endgenerate

    // ---------------- interrupt ----------------
    always_comb begin
        w_w1c_or = 1'b0;
        w_ini_or = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            if (W1C_MASK[i]) begin
                w_w1c_or = w_w1c_or | (|w_q[i]);
                w_ini_or = w_ini_or | (|INI[i*DW +: DW]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_irq <= w_ini_or;
        else        r_irq <= w_w1c_or;
    end

    assign irq = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_reg_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_bank
// Purpose  : Self-checking bench for reg_bank (DW=8, NREG=6, AW=3; reg2 RW
//            with reset value A5, reg4 RO = 5A, reg5 W1C). Directed vector
//            table, hand-written W1C / shadow / reset sequences and random
//            traffic compared every cycle against an array-based model.
// Options  : REG_BANK_SHADOW_EN - exercises commit / shadow behaviour
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_bank;

    localparam int DW   = 8;
    localparam int NREG = 6;
    localparam int AW   = 3;
    localparam logic [NREG*DW-1:0] INI  = 48'h005A_00A5_0000;
    localparam logic [NREG-1:0]    ROM  = 6'b010000;
    localparam logic [NREG-1:0]    W1CM = 6'b100000;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               req;
    logic               we;
    logic [AW-1:0]      addr;
    logic [DW-1:0]      wdata;
    logic               ack;
    logic [DW-1:0]      rdata;
    logic               err;
    logic [NREG*DW-1:0] hw_set;
    logic [NREG*DW-1:0] dout;
    logic               irq;
    logic               commit;

    int n_chk  = 0;
    int n_fail = 0;

    reg_bank #(
        .DW(DW), .NREG(NREG), .AW(AW), .INI(INI),
        .RO_MASK(ROM), .W1C_MASK(W1CM), .DLY(1)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .ack    (ack),
        .rdata  (rdata),
        .err    (err),
        .hw_set (hw_set),
`ifdef REG_BANK_SHADOW_EN
        .commit (commit),
`endif
        .dout   (dout),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [DW-1:0] m_act [NREG];   // what dout shows
    logic [DW-1:0] m_sh  [NREG];   // what the bus sees for RW registers
    logic          m_busy;
    logic          m_ack;
    logic          m_err;
    logic          m_irq;
    logic [DW-1:0] m_rdata;

    function automatic logic is_rw(input int i);
        return !ROM[i] && !W1CM[i];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) begin
            m_act[i] = INI[i*DW +: DW];
            m_sh[i]  = INI[i*DW +: DW];
        end
        m_busy = 1'b0; m_ack = 1'b0; m_err = 1'b0; m_rdata = '0;
        m_irq = 1'b0;
        for (int i = 0; i < NREG; i++)
            if (W1CM[i] && INI[i*DW +: DW] != 0) m_irq = 1'b1;
    endtask

    // One rising edge worth of behaviour, from the bank's rules.
    task automatic model_step();
        logic status_any;
        int   hit;
        if (!rst_n) begin
            model_reset();
            return;
        end
        status_any = 1'b0;
        for (int i = 0; i < NREG; i++)
            if (W1CM[i] && m_act[i] != 0) status_any = 1'b1;
        hit = -1;
        m_ack = 1'b0; m_err = 1'b0; m_rdata = '0;
        if (!m_busy && req) begin
            m_busy = 1'b1;
            m_ack  = 1'b1;
            if (int'(addr) >= NREG) m_err = 1'b1;
            else if (we) begin
                if (ROM[addr] && !W1CM[addr]) m_err = 1'b1;
                else if (!ROM[addr])          hit = int'(addr);
            end else begin
`ifdef REG_BANK_SHADOW_EN
                m_rdata = is_rw(int'(addr)) ? m_sh[addr] : m_act[addr];
`else
                m_rdata = m_act[addr];
`endif
            end
        end else begin
            m_busy = 1'b0;
        end
        for (int i = 0; i < NREG; i++) begin
            if (W1CM[i]) begin
                logic [DW-1:0] clr;
                clr = (hit == i) ? wdata : '0;
                m_act[i] = (m_act[i] & ~clr) | hw_set[i*DW +: DW];
            end else if (is_rw(i) && hit == i) begin
`ifdef REG_BANK_SHADOW_EN
                m_sh[i] = wdata;
`else
                m_act[i] = wdata;
`endif
            end
        end
`ifdef REG_BANK_SHADOW_EN
        if (commit)
            for (int i = 0; i < NREG; i++)
                if (is_rw(i)) m_act[i] = m_sh[i];
`endif
        m_irq = status_any;
    endtask

    function automatic logic [NREG*DW-1:0] model_dout();
        logic [NREG*DW-1:0] v;
        for (int i = 0; i < NREG; i++) v[i*DW +: DW] = m_act[i];
        return v;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Advance one clock: model sees the edge, outputs compared at the negedge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("model_ctl", 64'({ack, err, rdata, irq}), 64'({m_ack, m_err, m_rdata, m_irq}));
        check("model_dout", 64'(dout), 64'(model_dout()));
    endtask

    task automatic do_access(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             output logic [DW-1:0] rd, output logic er);
        req = 1'b1; we = w; addr = a; wdata = d;
        cycle();
        check("ack_latency", 64'(ack), 64'd1);
        rd = rdata;
        er = err;
        req = 1'b0;
        cycle();
    endtask

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
    } vec_t;

    vec_t vt [11];

    initial begin
        logic [DW-1:0] rd;
        logic          er;

        vt[0]  = '{1'b1, 3'd3, 8'h3C, 8'h00, 1'b0};  // write RW
        vt[1]  = '{1'b0, 3'd3, 8'h00, 8'h3C, 1'b0};  // read back
        vt[2]  = '{1'b0, 3'd2, 8'h00, 8'hA5, 1'b0};  // reset value
        vt[3]  = '{1'b1, 3'd4, 8'hFF, 8'h00, 1'b1};  // write RO -> err
        vt[4]  = '{1'b0, 3'd4, 8'h00, 8'h5A, 1'b0};  // RO unchanged
        vt[5]  = '{1'b0, 3'd7, 8'h00, 8'h00, 1'b1};  // read out of range
        vt[6]  = '{1'b1, 3'd6, 8'h12, 8'h00, 1'b1};  // write out of range
        vt[7]  = '{1'b0, 3'd6, 8'h00, 8'h00, 1'b1};  // read first illegal index
        vt[8]  = '{1'b1, 3'd0, 8'hFF, 8'h00, 1'b0};
        vt[9]  = '{1'b0, 3'd0, 8'h00, 8'hFF, 1'b0};
        vt[10] = '{1'b0, 3'd5, 8'h00, 8'h00, 1'b0};  // status reg empty

        rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        hw_set = '0; commit = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_dout_reg2", 64'(dout[23:16]), 64'hA5);
        check("rst_ctl", 64'({ack, err, rdata, irq}), 64'h0);
        check("rst_dout", 64'(dout), 64'(INI));
        rst_n = 1'b1;
        cycle();

        // ---- table-driven vectors ----
        for (int k = 0; k < 11; k++) begin
            do_access(vt[k].we, vt[k].addr, vt[k].wdata, rd, er);
            check($sformatf("vec%0d_rdata", k), 64'(rd), 64'(vt[k].exp_rdata));
            check($sformatf("vec%0d_err", k), 64'(er), 64'(vt[k].exp_err));
        end
        check("ro_dout", 64'(dout[39:32]), 64'h5A);

        // ---- W1C status register ----
        hw_set = 48'h11 << 40;
        cycle();
        hw_set = '0;
        check("w1c_set", 64'(dout[47:40]), 64'h11);
        check("irq_lag", 64'(irq), 64'd0);
        cycle();
        check("irq_set", 64'(irq), 64'd1);
        do_access(1'b1, 3'd5, 8'h01, rd, er);
        check("w1c_clr0", 64'(dout[47:40]), 64'h10);
        check("w1c_clr0_err", 64'(er), 64'd0);
        check("irq_hold", 64'(irq), 64'd1);
        do_access(1'b1, 3'd5, 8'h10, rd, er);
        check("w1c_clr4", 64'(dout[47:40]), 64'h00);
        check("irq_clear", 64'(irq), 64'd0);
        // set and clear of bit0 on the same edge: set wins
        req = 1'b1; we = 1'b1; addr = 3'd5; wdata = 8'h01; hw_set = 48'h01 << 40;
        cycle();
        req = 1'b0; hw_set = '0;
        check("set_wins", 64'(dout[40]), 64'd1);
        cycle();
        do_access(1'b1, 3'd5, 8'hFF, rd, er);
        check("w1c_empty", 64'(dout[47:40]), 64'h00);

`ifdef REG_BANK_SHADOW_EN
        // ---- shadow / commit ----
        do_access(1'b1, 3'd1, 8'h77, rd, er);
        check("shadow_hidden", 64'(dout[15:8]), 64'h00);
        do_access(1'b0, 3'd1, 8'h00, rd, er);
        check("shadow_read", 64'(rd), 64'h77);
        commit = 1'b1;
        cycle();
        commit = 1'b0;
        check("commit", 64'(dout[15:8]), 64'h77);
        req = 1'b1; we = 1'b1; addr = 3'd1; wdata = 8'h11; commit = 1'b1;
        cycle();
        req = 1'b0; commit = 1'b0;
        check("commit_same", 64'(dout[15:8]), 64'h11);
        cycle();
`else
        do_access(1'b1, 3'd1, 8'h77, rd, er);
        check("direct_write", 64'(dout[15:8]), 64'h77);
`endif

        // ---- random traffic against the model ----
        for (int n = 0; n < 400; n++) begin
            req    = 1'($urandom_range(0, 1));
            we     = 1'($urandom_range(0, 1));
            addr   = AW'($urandom_range(0, 7));
            wdata  = DW'($urandom);
            hw_set = 48'({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom});
            commit = ($urandom_range(0, 3) == 0);
            cycle();
        end
        req = 1'b0; hw_set = '0; commit = 1'b0;
        cycle();

        // ---- reset during RESP ----
        req = 1'b1; we = 1'b1; addr = 3'd0; wdata = 8'h5C;
        cycle();
        check("resp_ack", 64'(ack), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check("reset_ack", 64'(ack), 64'd0);
        check("reset_dout", 64'(dout), 64'(INI));
        req = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        do_access(1'b0, 3'd2, 8'h00, rd, er);
        check("post_reset_read", 64'(rd), 64'hA5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
